// File: rtl/load_counter_pkg.sv
// Shared definitions for the programmable terminal-count counter.
package load_counter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef logic [WIDTH_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/load_counter_cmp.sv
// Terminal-count detector: flags when the running count has reached or passed load.
module load_counter_cmp
    import load_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] load,
    output logic             terminal
);

    // >= rather than == so a load lowered below the count wraps on the next edge
    // instead of running the counter all the way through 2^WIDTH.
    assign terminal = (count >= load);

endmodule

// File: rtl/load_counter.sv
// Free-running counter giving one registered out event every load+1 cycles.
// Define LOAD_COUNTER_TOGGLE_EN to make out toggle on each terminal (square wave).
module load_counter
    import load_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load,
    output logic             out
);

    logic [WIDTH-1:0] count;
    logic             terminal;

    load_counter_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .count    (count),
        .load     (load),
        .terminal (terminal)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            out   <= 1'b0;
        end else if (terminal) begin
            count <= '0;
`ifdef LOAD_COUNTER_TOGGLE_EN
            out   <= ~out;
`else
            out   <= 1'b1;
`endif
        end else begin
            count <= count + 1'b1;
`ifdef LOAD_COUNTER_TOGGLE_EN
            out   <= out;
`else
            out   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_load_counter.sv
// Self-checking bench for load_counter: a reference model pushes the expected
// out value per edge into a scoreboard queue, popped and compared after the edge.
module tb_load_counter;
    import load_counter_pkg::*;

    logic clk;
    logic rst;
    cnt_t load;
    logic out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    cnt_t m_cnt;
    logic m_out;
    logic exp_q[$];

    load_counter #(
        .WIDTH (WIDTH_DEFAULT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model for the upcoming edge, push its out, then compare after the edge.
    task automatic tick(input string tag);
        logic exp_out;
        logic term;
        if (!rst) begin
            m_cnt = '0;
            m_out = 1'b0;
        end else begin
            term = (m_cnt >= load);
            if (term) begin
                m_cnt = '0;
`ifdef LOAD_COUNTER_TOGGLE_EN
                m_out = ~m_out;
`else
                m_out = 1'b1;
`endif
            end else begin
                m_cnt = m_cnt + 1'b1;
`ifndef LOAD_COUNTER_TOGGLE_EN
                m_out = 1'b0;
`endif
            end
        end
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            exp_out = exp_q.pop_front();
            check({tag, "_out"}, {31'd0, out}, {31'd0, exp_out});
        end
        check({tag, "_count"}, {28'd0, dut.count}, {28'd0, m_cnt});
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        m_cnt = '0;
        m_out = 1'b0;
        exp_q.delete();
        check({tag, "_async_out"}, {31'd0, out}, 32'd0);
        check({tag, "_async_count"}, {28'd0, dut.count}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        load  = 4'd3;
        m_cnt = '0;
        m_out = 1'b0;

        // Reset hold
        #1;
        check("reset_out", {31'd0, out}, 32'd0);
        check("reset_count", {28'd0, dut.count}, 32'd0);
        for (int i = 0; i < 5; i++) tick("hold");

        // Basic period with load=3: first pulse on edge 4 after release
        release_reset();
        for (int i = 1; i <= 12; i++) begin
            tick("basic");
`ifndef LOAD_COUNTER_TOGGLE_EN
            check("basic_pulse_pos", {31'd0, out}, (i % 4 == 0) ? 32'd1 : 32'd0);
`endif
        end

        // Zero load
        load = 4'd0;
        for (int i = 0; i < 6; i++) tick("zero");

        // Load shrink: run to count 10 with load=15, then drop load to 3
        async_reset("shrink");
        load = 4'd15;
        release_reset();
        for (int i = 0; i < 10; i++) tick("shrink_up");
        check("shrink_at10", {28'd0, dut.count}, 32'd10);
        load = 4'd3;
        tick("shrink_wrap");
`ifndef LOAD_COUNTER_TOGGLE_EN
        check("shrink_pulse", {31'd0, out}, 32'd1);
`endif
        for (int i = 0; i < 8; i++) tick("shrink_after");

        // Mid-period reset at count 2
        async_reset("mid");
        load = 4'd3;
        release_reset();
        tick("mid_a");
        tick("mid_b");
        check("mid_at2", {28'd0, dut.count}, 32'd2);
        async_reset("mid2");
        for (int i = 0; i < 2; i++) tick("mid_held");
        release_reset();
        for (int i = 0; i < 8; i++) tick("mid_release");

        // Load raised mid-period stretches the period
        load = 4'd7;
        for (int i = 0; i < 10; i++) tick("raise");

        // Max load: full-range count, no overflow
        async_reset("max");
        load = 4'd15;
        release_reset();
        for (int i = 0; i < 40; i++) tick("max");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
